// File: rtl/wallace_mac_ctrl_pkg.sv
// Shared types and constants for the Wallace-multiplier MAC wrapper.
// Operand/product widths are fixed by the external 4x4 multiplier.
package wallace_mac_ctrl_pkg;

    localparam int OP_W      = 4;
    localparam int PROD_W    = 9;
    localparam int ACC_W_DEF = 16;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        S_ACC   = 2'd0,
        S_CLOSE = 2'd1,
        S_OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/wallace_mac_ctrl_mac_accumulator.sv
// Stage-2 accumulate: adds the multiplier product, tracks term count and overflow, holds the frame result.
// MAC_SATURATE_EN defined: accumulator clamps to all-ones on carry-out; otherwise it wraps.
module wallace_mac_ctrl_mac_accumulator
    import wallace_mac_ctrl_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s1_valid_i,
    input  logic              s1_last_i,
    input  logic [PROD_W-1:0] mul_p_i,
    input  logic              out_xfer_i,
    output logic [ACC_W-1:0]  out_sum_o,
    output logic [CNT_W-1:0]  out_count_o,
    output logic              out_ovf_o,
    output logic              out_valid_o
);

    logic [ACC_W-1:0] acc_q, acc_d, acc_upd;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_upd;
    logic             ovf_q, ovf_d, ovf_upd;
    logic [ACC_W-1:0] osum_q, osum_d;
    logic [CNT_W-1:0] ocnt_q, ocnt_d;
    logic             oovf_q, oovf_d;
    logic             ovld_q, ovld_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        sum = {1'b0, acc_q} + {{(ACC_W+1-PROD_W){1'b0}}, mul_p_i};
`ifdef MAC_SATURATE_EN
        acc_upd = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_upd = sum[ACC_W-1:0];
`endif
        cnt_upd = cnt_q + CNT_W'(1);
        ovf_upd = ovf_q | sum[ACC_W];

        acc_d  = acc_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        osum_d = osum_q;
        ocnt_d = ocnt_q;
        oovf_d = oovf_q;
        ovld_d = ovld_q & ~out_xfer_i;

        if (s1_valid_i) begin
            if (s1_last_i) begin
                // Last term: publish the updated totals and restart the frame from zero.
                osum_d = acc_upd;
                ocnt_d = cnt_upd;
                oovf_d = ovf_upd;
                ovld_d = 1'b1;
                acc_d  = '0;
                cnt_d  = '0;
                ovf_d  = 1'b0;
            end else begin
                acc_d = acc_upd;
                cnt_d = cnt_upd;
                ovf_d = ovf_upd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            osum_q <= '0;
            ocnt_q <= '0;
            oovf_q <= 1'b0;
            ovld_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            osum_q <= osum_d;
            ocnt_q <= ocnt_d;
            oovf_q <= oovf_d;
            ovld_q <= ovld_d;
        end
    end

    assign out_sum_o   = osum_q;
    assign out_count_o = ocnt_q;
    assign out_ovf_o   = oovf_q;
    assign out_valid_o = ovld_q;

endmodule

// File: rtl/wallace_mac_ctrl.sv
// Dot-product MAC wrapper around an external 4x4 Wallace multiplier; frame result on valid/ready.
// Optional MAC_SATURATE_EN selects a saturating accumulator instead of a wrapping one.
module wallace_mac_ctrl
    import wallace_mac_ctrl_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic [PROD_W-1:0] mul_p,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              out_valid,
    input  logic              out_ready
);

    state_t          state_q;
    logic [OP_W-1:0] mul_a_q, mul_b_q;
    logic            s1_valid_q, s1_last_q;
    logic            in_xfer, out_xfer;

    // in_ready depends on state only, so no combinational path from in_valid or out_ready.
    assign in_ready = (state_q == S_ACC);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ACC;
        end else begin
            case (state_q)
                S_ACC:   if (in_xfer && in_last) state_q <= S_CLOSE;
                S_CLOSE: state_q <= S_OUT;
                S_OUT:   if (out_xfer) state_q <= S_ACC;
                default: state_q <= S_ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= in_xfer;
            if (in_xfer) begin
                mul_a_q   <= in_a;
                mul_b_q   <= in_b;
                s1_last_q <= in_last;
            end
        end
    end

    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;

    wallace_mac_ctrl_mac_accumulator #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .s1_valid_i  (s1_valid_q),
        .s1_last_i   (s1_last_q),
        .mul_p_i     (mul_p),
        .out_xfer_i  (out_xfer),
        .out_sum_o   (out_sum),
        .out_count_o (out_count),
        .out_ovf_o   (out_ovf),
        .out_valid_o (out_valid)
    );

endmodule

// File: tb/tb_wallace_mac_ctrl.sv
// Drives one operand stream into a 16-bit and a 9-bit accumulator instance and scores both.
module tb_wallace_mac_ctrl;

`ifdef MAC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_a, in_b;
    logic        in_last, in_valid, out_ready;

    logic        in_ready, in_ready9;
    logic [3:0]  mul_a, mul_b, mul_a9, mul_b9;
    logic [8:0]  mul_p, mul_p9;
    logic [15:0] out_sum;
    logic [8:0]  out_sum9;
    logic [7:0]  out_count, out_count9;
    logic        out_ovf, out_ovf9, out_valid, out_valid9;

    always #5 clk = ~clk;

    assign mul_p  = 9'(mul_a)  * 9'(mul_b);
    assign mul_p9 = 9'(mul_a9) * 9'(mul_b9);

    wallace_mac_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready), .mul_a(mul_a), .mul_b(mul_b),
        .mul_p(mul_p), .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    wallace_mac_ctrl #(.ACC_W(9), .CNT_W(8)) u_dut9 (
        .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready9), .mul_a(mul_a9), .mul_b(mul_b9),
        .mul_p(mul_p9), .out_sum(out_sum9), .out_count(out_count9), .out_ovf(out_ovf9),
        .out_valid(out_valid9), .out_ready(out_ready)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;
    int fa [0:299];
    int fb [0:299];
    int fn;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference result of an unbounded dot product squeezed into a w-bit accumulator.
    function automatic int exp_sum(input int total, input int w);
        int lim = 1 << w;
        if (SAT && total >= lim) return lim - 1;
        return total % lim;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic put(input logic [3:0] a, input logic [3:0] b, input logic last);
        int budget = 20;
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        while (!in_ready && budget > 0) begin
            tick();
            budget--;
        end
        check_val("in_ready_wait", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_a = 4'($urandom); in_b = 4'($urandom); in_last = 1'($urandom);
    endtask

    task automatic do_frame(input int max_gap, input int stall);
        int total = 0;
        for (int i = 0; i < fn; i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                out_ready = 1'($urandom);
                tick();
            end
            put(4'(fa[i]), 4'(fb[i]), i == fn - 1);
            total += fa[i] * fb[i];
        end
        out_ready = 1'b0;
        check_val("mul_a_last", 32'(mul_a), 32'(fa[fn-1]));
        check_val("mul_b_last", 32'(mul_b), 32'(fb[fn-1]));
        check_val("close_in_ready", 32'(in_ready), 32'd0);
        check_val("close_out_valid", 32'(out_valid), 32'd0);
        tick();
        check_val("lat_out_valid", 32'(out_valid), 32'd1);
        check_val("lat_in_ready", 32'(in_ready), 32'd0);
        repeat (stall) begin
            tick();
            check_val("stall_out_valid", 32'(out_valid), 32'd1);
            check_val("stall_in_ready", 32'(in_ready), 32'd0);
            check_val("stall_sum", 32'(out_sum), 32'(exp_sum(total, 16)));
        end
        check_val("sum16", 32'(out_sum), 32'(exp_sum(total, 16)));
        check_val("count16", 32'(out_count), 32'(fn % 256));
        check_val("ovf16", 32'(out_ovf), 32'(total >= 65536));
        check_val("valid9", 32'(out_valid9), 32'd1);
        check_val("sum9", 32'(out_sum9), 32'(exp_sum(total, 9)));
        check_val("count9", 32'(out_count9), 32'(fn % 256));
        check_val("ovf9", 32'(out_ovf9), 32'(total >= 512));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("post_out_valid", 32'(out_valid), 32'd0);
        check_val("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_sum", 32'(out_sum), 32'd0);
        check_val("rst_out_count", 32'(out_count), 32'd0);
        check_val("rst_mul_a", 32'(mul_a), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        fn = 3; fa[0] = 3; fb[0] = 5; fa[1] = 15; fb[1] = 15; fa[2] = 2; fb[2] = 7;
        do_frame(0, 0);

        fn = 1; fa[0] = 15; fb[0] = 15;
        do_frame(0, 0);

        fn = 2; fa[0] = 15; fb[0] = 15; fa[1] = 15; fb[1] = 15;
        do_frame(0, 5);

        fn = 3; fa[2] = 15; fb[2] = 15;
        do_frame(0, 0);

        // Abort a partial frame with reset, then make sure nothing leaks into the next one.
        put(4'd9, 4'd9, 1'b0);
        put(4'd7, 4'd7, 1'b0);
        rst_n = 1'b0;
        #1;
        check_val("midrst_mul_a", 32'(mul_a), 32'd0);
        check_val("midrst_out_valid", 32'(out_valid), 32'd0);
        check_val("midrst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        fn = 1; fa[0] = 1; fb[0] = 1;
        do_frame(0, 0);

        fn = 300;
        for (int i = 0; i < 300; i++) begin
            fa[i] = 15; fb[i] = 15;
        end
        do_frame(0, 1);

        for (int f = 0; f < 40; f++) begin
            fn = $urandom_range(1, 20);
            for (int i = 0; i < fn; i++) begin
                fa[i] = $urandom_range(0, 15);
                fb[i] = $urandom_range(0, 15);
            end
            do_frame(2, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
